// File: rtl/divisor_booth_seq.sv
// Sequential signed divider: one restoring step per clock on operand magnitudes,
// followed by a single sign fix-up cycle. Start/busy/done handshake.
module divisor_booth_seq #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t           state_reg;
  logic [CW-1:0]    count_reg;
  logic [WIDTH-1:0] p_reg;      // partial remainder, always < |divisor| between steps
  logic [WIDTH-1:0] a_reg;      // dividend magnitude shifting out, quotient bits shifting in
  logic [WIDTH-1:0] dmag_reg;   // unsigned, so |-2^(WIDTH-1)| fits
  logic             sign_n_reg;
  logic             sign_d_reg;
  logic             dzero_reg;

  logic [WIDTH-1:0] dividend_mag;
  logic [WIDTH-1:0] divisor_mag;
  logic [WIDTH:0]   p_shift;
  logic [WIDTH-1:0] p_sub;
  logic             q_bit;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;
  logic [WIDTH-1:0] n_fix;

  always_comb begin
    dividend_mag = dividend[WIDTH-1] ? (~dividend + ONE) : dividend;
    divisor_mag  = divisor[WIDTH-1]  ? (~divisor + ONE)  : divisor;
    // The shifted remainder needs WIDTH+1 bits only for the compare; after a
    // successful subtract the result is below |divisor| and fits WIDTH bits.
    p_shift = {p_reg, a_reg[WIDTH-1]};
    q_bit   = (p_shift >= {1'b0, dmag_reg});
    p_sub   = p_shift[WIDTH-1:0] - dmag_reg;
    q_fix   = (sign_n_reg ^ sign_d_reg) ? (~a_reg + ONE) : a_reg;
    r_fix   = sign_n_reg ? (~p_reg + ONE) : p_reg;
    n_fix   = sign_n_reg ? (~a_reg + ONE) : a_reg;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      count_reg  <= '0;
      p_reg      <= '0;
      a_reg      <= '0;
      dmag_reg   <= '0;
      sign_n_reg <= 1'b0;
      sign_d_reg <= 1'b0;
      dzero_reg  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      q          <= '0;
      r          <= '0;
      div_zero   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            sign_n_reg <= dividend[WIDTH-1];
            sign_d_reg <= divisor[WIDTH-1];
            a_reg      <= dividend_mag;
            dmag_reg   <= divisor_mag;
            p_reg      <= '0;
            count_reg  <= CW'(WIDTH);
            dzero_reg  <= (divisor == '0);
            busy       <= 1'b1;
            state_reg  <= (divisor == '0) ? FIX : CALC;
          end
        end
        CALC: begin
          p_reg     <= q_bit ? p_sub : p_shift[WIDTH-1:0];
          a_reg     <= {a_reg[WIDTH-2:0], q_bit};
          count_reg <= count_reg - CW'(1);
          if (count_reg == CW'(1)) begin
            state_reg <= FIX;
          end
        end
        FIX: begin
          // On divide by zero a_reg was never shifted, so it still holds |dividend|.
          if (dzero_reg) begin
            q        <= '1;
            r        <= n_fix;
            div_zero <= 1'b1;
          end else begin
            q        <= q_fix;
            r        <= r_fix;
            div_zero <= 1'b0;
          end
          done      <= 1'b1;
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
